// File: rtl/gpio_ctrl_v2_pkg.sv
// gpio_ctrl_v2_pkg
// Shared definitions for the GPIO controller v2: register offsets, the
// per-region layout (32-pin banks at a 4-byte stride inside 0x40-byte
// regions) and the address-decode error helper used by the APB front end.
// Optional feature macro: GPIO_V2_FILTER_EN (enables FILTER_CFG at 0x240).
package gpio_ctrl_v2_pkg;

    localparam logic [11:0] OFF_DATA_IN     = 12'h000;
    localparam logic [11:0] OFF_DATA_OUT    = 12'h040;
    localparam logic [11:0] OFF_OUT_SET     = 12'h080;
    localparam logic [11:0] OFF_OUT_CLR     = 12'h0C0;
    localparam logic [11:0] OFF_OUT_EN      = 12'h100;
    localparam logic [11:0] OFF_POS_EN      = 12'h140;
    localparam logic [11:0] OFF_NEG_EN      = 12'h180;
    localparam logic [11:0] OFF_LVL_MODE    = 12'h1C0;
    localparam logic [11:0] OFF_INTR_STATUS = 12'h200;
    localparam logic [11:0] OFF_FILTER_CFG  = 12'h240;

    localparam int          BANK_STRIDE = 4;
    localparam logic [11:0] REGION_SIZE = 12'h040;
    localparam int          BANK_LSB    = $clog2(BANK_STRIDE);
    localparam int          REGION_LSB  = $clog2(REGION_SIZE);

    localparam logic [5:0] RGN_DATA_IN     = OFF_DATA_IN[11:REGION_LSB];
    localparam logic [5:0] RGN_DATA_OUT    = OFF_DATA_OUT[11:REGION_LSB];
    localparam logic [5:0] RGN_OUT_SET     = OFF_OUT_SET[11:REGION_LSB];
    localparam logic [5:0] RGN_OUT_CLR     = OFF_OUT_CLR[11:REGION_LSB];
    localparam logic [5:0] RGN_OUT_EN      = OFF_OUT_EN[11:REGION_LSB];
    localparam logic [5:0] RGN_POS_EN      = OFF_POS_EN[11:REGION_LSB];
    localparam logic [5:0] RGN_NEG_EN      = OFF_NEG_EN[11:REGION_LSB];
    localparam logic [5:0] RGN_LVL_MODE    = OFF_LVL_MODE[11:REGION_LSB];
    localparam logic [5:0] RGN_INTR_STATUS = OFF_INTR_STATUS[11:REGION_LSB];
    localparam logic [5:0] RGN_FILTER_CFG  = OFF_FILTER_CFG[11:REGION_LSB];

`ifdef GPIO_V2_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    // FILTER_CFG is a single register, so only its bank-0 slot is mapped.
    function automatic logic addr_err(input logic [11:0] addr, input int unsigned banks);
        logic [5:0] region;
        logic [3:0] bank;
        region = addr[11:REGION_LSB];
        bank   = addr[REGION_LSB-1:BANK_LSB];
        return (addr[BANK_LSB-1:0] != '0)
            || (32'(bank) >= banks)
            || (region > RGN_FILTER_CFG)
            || ((region == RGN_FILTER_CFG) && (!FILTER_EN || (bank != '0)));
    endfunction

endpackage

// File: rtl/gpio_controller_v2_in_path.sv
// gpio_controller_v2_in_path
// Input path for one 32-pin bank: synchroniser, optional glitch filter
// (GPIO_V2_FILTER_EN), edge-history register and interrupt event generation.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   pin_in[31:0]                    asynchronous pad inputs
//   pos_en, neg_en, lvl_mode[31:0]  per-pin event configuration
//   filter_cfg[FILTER_W-1:0]        filter threshold (filter builds only)
//   data_in[31:0]                   synchronised (filtered) pin values
//   evt[31:0]                       per-pin event, sets status at next edge
module gpio_controller_v2_in_path
    import gpio_ctrl_v2_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef GPIO_V2_FILTER_EN
  , parameter int FILTER_W    = 8
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         pin_in,
    input  logic [31:0]         pos_en,
    input  logic [31:0]         neg_en,
    input  logic [31:0]         lvl_mode,
`ifdef GPIO_V2_FILTER_EN
    input  logic [FILTER_W-1:0] filter_cfg,
`endif
    output logic [31:0]         data_in,
    output logic [31:0]         evt
);

    logic [SYNC_STAGES-1:0][31:0] sync_q;
    logic [31:0]                  sync_out;
    logic [31:0]                  filt;
    logic [31:0]                  prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_V2_FILTER_EN
    logic [31:0]         filt_q;
    logic [FILTER_W-1:0] cnt_q [32];

    // A change is accepted only after it has been stable for filter_cfg+1 samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (sync_out[i] != filt_q[i]) begin
                    if (cnt_q[i] == filter_cfg) begin
                        filt_q[i] <= sync_out[i];
                        cnt_q[i]  <= '0;
                    end else begin
                        cnt_q[i]  <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_out;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= filt;
    end

    assign data_in = filt;
    assign evt     = ( lvl_mode & ((filt & pos_en) | (~filt & neg_en)))
                   | (~lvl_mode & ((filt & ~prev_q & pos_en) | (~filt & prev_q & neg_en)));

endmodule

// File: rtl/gpio_controller_v2.sv
// gpio_controller_v2
// APB-attached GPIO controller, NUM_GPIO pins in 32-pin banks. Provides
// DATA_IN, DATA_OUT with atomic SET/CLR, OUT_EN, per-pin edge/level interrupt
// configuration and a W1C interrupt status. Zero-wait-state APB slave.
// Optional feature macro: GPIO_V2_FILTER_EN (per-pin glitch filter + FILTER_CFG).
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   paddr, psel, penable, pwrite,
//   pstrb, pwdata                     APB request
//   prdata, pready, pslverr           APB response (combinational in access)
//   interrupt                         registered OR of all status bits
//   gpio_in_data                      asynchronous pad inputs
//   gpio_out_data, gpio_out_enable    pad output value / driver enable
module gpio_controller_v2
    import gpio_ctrl_v2_pkg::*;
#(
    parameter int NUM_GPIO    = 256,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [11:0]         paddr,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [3:0]          pstrb,
    input  logic [31:0]         pwdata,
    output logic [31:0]         prdata,
    output logic                pready,
    output logic                pslverr,
    output logic                interrupt,
    input  logic [NUM_GPIO-1:0] gpio_in_data,
    output logic [NUM_GPIO-1:0] gpio_out_data,
    output logic [NUM_GPIO-1:0] gpio_out_enable
);

    localparam int BANKS = NUM_GPIO / 32;

    if (NUM_GPIO < 32 || NUM_GPIO > 256 || (NUM_GPIO % 32) != 0 ||
        SYNC_STAGES < 2 || FILTER_W < 1 || FILTER_W > 32) begin : g_param_check
        $error("gpio_controller_v2: unsupported parameter set");
    end

    logic                access, bad_addr, wr_en;
    logic [5:0]          region;
    logic [3:0]          bank;
    logic [31:0]         wmask, rd_word;
    logic [NUM_GPIO-1:0] lane_mask, lane_data, hit_bits, w1c_bits, rd_vec;
    logic [NUM_GPIO-1:0] data_out_q, out_en_q, pos_en_q, neg_en_q, lvl_mode_q, status_q;
    logic [NUM_GPIO-1:0] data_in_all, evt_all;
    logic                irq_q;
`ifdef GPIO_V2_FILTER_EN
    logic [FILTER_W-1:0] filter_cfg_q;
`endif

    assign access   = psel & penable;
    assign region   = paddr[11:REGION_LSB];
    assign bank     = paddr[REGION_LSB-1:BANK_LSB];
    assign bad_addr = addr_err(paddr, BANKS);
    assign wr_en    = access & pwrite & ~bad_addr;

    function automatic logic [NUM_GPIO-1:0] merge(input logic [NUM_GPIO-1:0] cur,
                                                  input logic [NUM_GPIO-1:0] data,
                                                  input logic [NUM_GPIO-1:0] mask);
        return (cur & ~mask) | (data & mask);
    endfunction

    // Place the strobed write word into the addressed bank's 32-bit lane.
    always_comb begin
        wmask     = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
        lane_mask = '0;
        lane_data = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (bank == 4'(b)) begin
                lane_mask[b*32 +: 32] = wmask;
                lane_data[b*32 +: 32] = pwdata;
            end
        end
        hit_bits = lane_mask & lane_data;
        w1c_bits = (wr_en && region == RGN_INTR_STATUS) ? hit_bits : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_q   <= '0;
            out_en_q     <= '0;
            pos_en_q     <= '0;
            neg_en_q     <= '0;
            lvl_mode_q   <= '0;
            status_q     <= '0;
            irq_q        <= 1'b0;
`ifdef GPIO_V2_FILTER_EN
            filter_cfg_q <= '0;
`endif
        end else begin
            if (wr_en) begin
                case (region)
                    RGN_DATA_OUT: data_out_q <= merge(data_out_q, lane_data, lane_mask);
                    RGN_OUT_SET:  data_out_q <= data_out_q | hit_bits;
                    RGN_OUT_CLR:  data_out_q <= data_out_q & ~hit_bits;
                    RGN_OUT_EN:   out_en_q   <= merge(out_en_q, lane_data, lane_mask);
                    RGN_POS_EN:   pos_en_q   <= merge(pos_en_q, lane_data, lane_mask);
                    RGN_NEG_EN:   neg_en_q   <= merge(neg_en_q, lane_data, lane_mask);
                    RGN_LVL_MODE: lvl_mode_q <= merge(lvl_mode_q, lane_data, lane_mask);
`ifdef GPIO_V2_FILTER_EN
                    RGN_FILTER_CFG:
                        filter_cfg_q <= (filter_cfg_q & ~wmask[FILTER_W-1:0])
                                      | (pwdata[FILTER_W-1:0] & wmask[FILTER_W-1:0]);
`endif
                    default: ;
                endcase
            end
            // Hardware events are ORed after the clear so a same-cycle set wins.
            status_q <= (status_q & ~w1c_bits) | evt_all;
            irq_q    <= |status_q;
        end
    end

    always_comb begin
        case (region)
            RGN_DATA_IN:     rd_vec = data_in_all;
            RGN_DATA_OUT:    rd_vec = data_out_q;
            RGN_OUT_EN:      rd_vec = out_en_q;
            RGN_POS_EN:      rd_vec = pos_en_q;
            RGN_NEG_EN:      rd_vec = neg_en_q;
            RGN_LVL_MODE:    rd_vec = lvl_mode_q;
            RGN_INTR_STATUS: rd_vec = status_q;
            default:         rd_vec = '0;
        endcase
        rd_word = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (bank == 4'(b)) rd_word = rd_vec[b*32 +: 32];
        end
`ifdef GPIO_V2_FILTER_EN
        if (region == RGN_FILTER_CFG) rd_word = 32'(filter_cfg_q);
`endif
        prdata  = (access && !bad_addr) ? rd_word : '0;
        pslverr = access & bad_addr;
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        gpio_controller_v2_in_path #(
            .SYNC_STAGES (SYNC_STAGES)
`ifdef GPIO_V2_FILTER_EN
          , .FILTER_W    (FILTER_W)
`endif
        ) u_in_path (
            .clk        (clk),
            .rst_n      (rst_n),
            .pin_in     (gpio_in_data[b*32 +: 32]),
            .pos_en     (pos_en_q[b*32 +: 32]),
            .neg_en     (neg_en_q[b*32 +: 32]),
            .lvl_mode   (lvl_mode_q[b*32 +: 32]),
`ifdef GPIO_V2_FILTER_EN
            .filter_cfg (filter_cfg_q),
`endif
            .data_in    (data_in_all[b*32 +: 32]),
            .evt        (evt_all[b*32 +: 32])
        );
    end

    assign pready          = 1'b1;
    assign interrupt       = irq_q;
    assign gpio_out_data   = data_out_q;
    assign gpio_out_enable = out_en_q;

endmodule

// File: tb/tb_gpio_controller_v2.sv
module tb_gpio_controller_v2;

    localparam int NUM_GPIO = 64;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [11:0]         paddr;
    logic                psel, penable, pwrite;
    logic [3:0]          pstrb;
    logic [31:0]         pwdata;
    logic [31:0]         prdata;
    logic                pready, pslverr, interrupt;
    logic [NUM_GPIO-1:0] gpio_in_data, gpio_out_data, gpio_out_enable;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    gpio_controller_v2 #(
        .NUM_GPIO    (NUM_GPIO),
        .SYNC_STAGES (2),
        .FILTER_W    (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .paddr           (paddr),
        .psel            (psel),
        .penable         (penable),
        .pwrite          (pwrite),
        .pstrb           (pstrb),
        .pwdata          (pwdata),
        .prdata          (prdata),
        .pready          (pready),
        .pslverr         (pslverr),
        .interrupt       (interrupt),
        .gpio_in_data    (gpio_in_data),
        .gpio_out_data   (gpio_out_data),
        .gpio_out_enable (gpio_out_enable)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic err);
        @(negedge clk);
        paddr = a; pwdata = d; pstrb = s; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1 err = pslverr;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        @(negedge clk);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata; err = pslverr;
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          nreg;
        logic [6:0]  seen;

        rst_n = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pstrb = 4'h0; pwdata = '0; gpio_in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: reset state
        check_eq("rst_out_data", gpio_out_data, 64'h0);
        check_eq("rst_out_en", gpio_out_enable, 64'h0);
        check_eq("rst_irq", interrupt, 0);
`ifdef GPIO_V2_FILTER_EN
        nreg = 10;
`else
        nreg = 9;
`endif
        for (int r = 0; r < nreg; r++) begin
            for (int b = 0; b < 2; b++) begin
                if (r == 9 && b != 0) continue;
                apb_read(12'(r * 64 + b * 4), rd, err);
                check_eq($sformatf("rst_rd_%0h", r * 64 + b * 4), rd, 0);
                check_eq($sformatf("rst_err_%0h", r * 64 + b * 4), err, 0);
            end
        end

        // 2: output data, atomic set/clear, byte strobes
        apb_write(12'h044, 32'hFFFF_0000, 4'hF, err);
        apb_write(12'h084, 32'h0000_000F, 4'hF, err);
        apb_write(12'h0C4, 32'h000F_0000, 4'hF, err);
        check_eq("set_clr_pins", gpio_out_data[63:32], 32'hFFF0_000F);
        apb_read(12'h044, rd, err);
        check_eq("set_clr_readback", rd, 32'hFFF0_000F);
        apb_read(12'h084, rd, err);
        check_eq("out_set_reads_0", rd, 0);
        apb_write(12'h040, 32'h1234_5678, 4'hF, err);
        apb_write(12'h040, 32'h0000_00AA, 4'b0001, err);
        check_eq("strb_byte0", gpio_out_data[31:0], 32'h1234_56AA);
        apb_write(12'h084, 32'hFFFF_FFFF, 4'b0010, err);
        check_eq("strb_set", gpio_out_data[63:32], 32'hFFF0_FF0F);
        apb_write(12'h100, 32'h0000_FFFF, 4'hF, err);
        check_eq("out_en", gpio_out_enable, 64'h0000_0000_0000_FFFF);
        gpio_in_data[63:32] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        apb_read(12'h004, rd, err);
        check_eq("data_in_bank1", rd, 32'hDEAD_BEEF);

        // 3: rising-edge interrupt latency, W1C, falling edge ignored
        apb_write(12'h140, 32'h1, 4'hF, err);
        @(negedge clk);
        paddr = 12'h200; pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
        gpio_in_data[0] = 1'b1;
        @(negedge clk); check_eq("lat_n_status", prdata[0], 0);
        @(negedge clk); check_eq("lat_n1_status", prdata[0], 0);
        @(negedge clk); check_eq("lat_n2_status", prdata[0], 1);
        check_eq("lat_n2_irq", interrupt, 0);
        @(negedge clk); check_eq("lat_n3_irq", interrupt, 1);
        psel = 1'b0; penable = 1'b0;
        apb_write(12'h200, 32'h1, 4'hF, err);
        @(negedge clk); check_eq("w1c_irq_hold", interrupt, 1);
        @(negedge clk); check_eq("w1c_irq_low", interrupt, 0);
        gpio_in_data[0] = 1'b0;
        repeat (5) @(negedge clk);
        apb_read(12'h200, rd, err);
        check_eq("fall_no_event", rd, 0);
        check_eq("fall_no_irq", interrupt, 0);

        // 4: level mode, clear while level persists, disable keeps status
        apb_write(12'h1C0, 32'h1, 4'hF, err);
        apb_write(12'h180, 32'h1, 4'hF, err);
        repeat (3) @(negedge clk);
        apb_read(12'h200, rd, err);
        check_eq("lvl_status", rd, 32'h1);
        apb_write(12'h200, 32'h1, 4'hF, err);
        apb_read(12'h200, rd, err);
        check_eq("lvl_w1c_reset", rd, 32'h1);
        apb_write(12'h180, 32'h0, 4'hF, err);
        apb_read(12'h200, rd, err);
        check_eq("disable_keeps", rd, 32'h1);
        apb_write(12'h200, 32'h1, 4'b0010, err);
        apb_read(12'h200, rd, err);
        check_eq("w1c_strb_masked", rd, 32'h1);
        apb_write(12'h200, 32'h1, 4'hF, err);
        apb_read(12'h200, rd, err);
        check_eq("w1c_clears", rd, 32'h0);
        apb_write(12'h1C0, 32'h0, 4'hF, err);

        // 5: address errors and read-only writes
        apb_read(12'h108, rd, err);
        check_eq("bank_oor_err", err, 1);
        check_eq("bank_oor_data", rd, 0);
        apb_read(12'h002, rd, err);
        check_eq("misalign_err", err, 1);
        check_eq("misalign_data", rd, 0);
        apb_read(12'h280, rd, err);
        check_eq("unmapped_err", err, 1);
        apb_write(12'h046, 32'h0, 4'hF, err);
        check_eq("bad_wr_err", err, 1);
        check_eq("bad_wr_nochange", gpio_out_data[63:32], 32'hFFF0_FF0F);
        apb_write(12'h104, 32'hFFFF_FFFF, 4'hF, err);
        check_eq("out_en_bank1_err", err, 0);
        apb_write(12'h108, 32'h0, 4'hF, err);
        check_eq("oor_wr_err", err, 1);
        check_eq("oor_wr_nochange", gpio_out_enable, 64'hFFFF_FFFF_0000_FFFF);
        apb_write(12'h000, 32'hFFFF_FFFF, 4'hF, err);
        check_eq("ro_wr_err", err, 0);
        apb_read(12'h004, rd, err);
        check_eq("ro_wr_ignored", rd, 32'hDEAD_BEEF);

`ifdef GPIO_V2_FILTER_EN
        // 6: glitch filter, threshold 4
        apb_write(12'h240, 32'h4, 4'hF, err);
        apb_read(12'h240, rd, err);
        check_eq("filter_cfg_rd", rd, 32'h4);
        apb_write(12'h140, 32'h20, 4'hF, err);
        @(negedge clk);
        paddr = 12'h000; pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
        gpio_in_data[5] = 1'b1;
        seen = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 2) gpio_in_data[5] = 1'b0;
            seen[0] = seen[0] | prdata[5];
        end
        check_eq("short_pulse_data", seen[0], 0);
        psel = 1'b0; penable = 1'b0;
        apb_read(12'h200, rd, err);
        check_eq("short_pulse_status", rd, 0);
        @(negedge clk);
        paddr = 12'h000; pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
        gpio_in_data[5] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            seen[k] = prdata[5];
            if (k == 5) gpio_in_data[5] = 1'b0;
        end
        check_eq("long_pulse_timing", seen, 7'b100_0000);
        psel = 1'b0; penable = 1'b0;
        repeat (3) @(negedge clk);
        apb_read(12'h200, rd, err);
        check_eq("long_pulse_status", rd, 32'h20);
`else
        apb_read(12'h240, rd, err);
        check_eq("filter_unmapped_err", err, 1);
        check_eq("filter_unmapped_data", rd, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
